// File: rtl/spi_host_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_host_bridge_if
// Brief    : Upstream stream, config-return and pad signals of the SPI host bridge.
// Revision : 1.0
// ============================================================================
interface spi_host_bridge_if #(
    parameter int SPI_WIDTH = 32
);
    logic [SPI_WIDTH-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [SPI_WIDTH-1:0] cfg_data;
    logic                 cfg_valid;
    logic [SPI_WIDTH-1:0] spi_data_o;
    logic                 spi_data_oe;
    logic [SPI_WIDTH-1:0] spi_data_i;
    logic                 spi_sck;
    logic                 spi_cs_n;
    logic                 oe_req;
    logic                 config_req;
    logic                 near_full;

    modport master (
        input  tx_data, tx_valid, spi_data_i, config_req, near_full,
        output tx_ready, cfg_data, cfg_valid, spi_data_o, spi_data_oe,
               spi_sck, spi_cs_n, oe_req
    );

    modport slave (
        output tx_data, tx_valid, spi_data_i, config_req, near_full,
        input  tx_ready, cfg_data, cfg_valid, spi_data_o, spi_data_oe,
               spi_sck, spi_cs_n, oe_req
    );
endinterface
`default_nettype wire

// File: rtl/spi_host_bridge.sv
`default_nettype none
// ============================================================================
// Module   : spi_host_bridge
// Brief    : Host-side master for one chip read channel: streams words out, fetches config words back.
// Revision : 1.0
// ============================================================================
module spi_host_bridge #(
    parameter int SPI_WIDTH   = 32,
    parameter int SCK_DIV     = 2,
    parameter int TURN_CYCLES = 2
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    spi_host_bridge_if.master bus
);
    localparam int CNT_MAX = (SCK_DIV > TURN_CYCLES) ? SCK_DIV : TURN_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] c_sck_last  = CNT_W'(SCK_DIV - 1);
    localparam logic [CNT_W-1:0] c_turn_last = CNT_W'(TURN_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SHIFT_LO = 3'd1,
        ST_SHIFT_HI = 3'd2,
        ST_RELEASE  = 3'd3,
        ST_CFG_WAIT = 3'd4,
        ST_CFG_LO   = 3'd5,
        ST_CFG_HI   = 3'd6,
        ST_RECLAIM  = 3'd7
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_nf_meta;
    logic                 r_nf_s;
    logic                 r_cr_meta;
    logic                 r_cr_s;
    logic                 r_tx_ready;
    logic [SPI_WIDTH-1:0] r_cfg_data;
    logic                 r_cfg_valid;
    logic [SPI_WIDTH-1:0] r_data_o;
    logic                 r_data_oe;
    logic                 r_sck;
    logic                 r_cs_n;
    logic                 r_oe_req;

    logic w_sck_done;
    logic w_turn_done;

    assign w_sck_done  = (r_cnt == c_sck_last);
    assign w_turn_done = (r_cnt == c_turn_last);

    // Both chip status lines arrive from another clock region.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nf_meta <= 1'b0;
            r_nf_s    <= 1'b0;
            r_cr_meta <= 1'b0;
            r_cr_s    <= 1'b0;
        end else begin
            r_nf_meta <= bus.near_full;
            r_nf_s    <= r_nf_meta;
            r_cr_meta <= bus.config_req;
            r_cr_s    <= r_cr_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_tx_ready  <= 1'b0;
            r_cfg_data  <= '0;
            r_cfg_valid <= 1'b0;
            r_data_o    <= '0;
            r_data_oe   <= 1'b1;
            r_sck       <= 1'b0;
            r_cs_n      <= 1'b1;
            r_oe_req    <= 1'b1;
        end else begin
            r_tx_ready  <= 1'b0;
            r_cfg_valid <= 1'b0;
            case (r_state)
                // Status lines are only looked at here, so a word in flight is never cut short.
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (r_cr_s) begin
                        r_cs_n    <= 1'b1;
                        r_data_oe <= 1'b0;
                        r_state   <= ST_RELEASE;
                    end else if (bus.tx_valid && !r_nf_s) begin
                        r_tx_ready <= 1'b1;
                        r_data_o   <= bus.tx_data;
                        r_cs_n     <= 1'b0;
                        r_state    <= ST_SHIFT_LO;
                    end else begin
                        r_cs_n <= 1'b1;
                    end
                end
                ST_SHIFT_LO: begin
                    if (w_sck_done) begin
                        r_cnt   <= '0;
                        r_sck   <= 1'b1;
                        r_state <= ST_SHIFT_HI;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                // cs_n is left low; IDLE decides whether the burst continues.
                ST_SHIFT_HI: begin
                    if (w_sck_done) begin
                        r_cnt   <= '0;
                        r_sck   <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (w_turn_done) begin
                        r_cnt    <= '0;
                        r_oe_req <= 1'b0;
                        r_state  <= ST_CFG_WAIT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                // Gives the chip's registered pad enable time to settle before sampling.
                ST_CFG_WAIT: begin
                    if (w_turn_done) begin
                        r_cnt   <= '0;
                        r_cs_n  <= 1'b0;
                        r_state <= ST_CFG_LO;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_CFG_LO: begin
                    if (w_sck_done) begin
                        r_cnt   <= '0;
                        r_sck   <= 1'b1;
                        r_state <= ST_CFG_HI;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_CFG_HI: begin
                    if (w_sck_done) begin
                        r_cnt       <= '0;
                        r_cfg_data  <= bus.spi_data_i;
                        r_cfg_valid <= 1'b1;
                        r_sck       <= 1'b0;
                        r_cs_n      <= 1'b1;
                        r_oe_req    <= 1'b1;
                        r_state     <= ST_RECLAIM;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                // The chip needs this gap to see oe_req and tristate before we drive again.
                ST_RECLAIM: begin
                    if (w_turn_done) begin
                        r_cnt     <= '0;
                        r_data_oe <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.tx_ready    = r_tx_ready;
    assign bus.cfg_data    = r_cfg_data;
    assign bus.cfg_valid   = r_cfg_valid;
    assign bus.spi_data_o  = r_data_o;
    assign bus.spi_data_oe = r_data_oe;
    assign bus.spi_sck     = r_sck;
    assign bus.spi_cs_n    = r_cs_n;
    assign bus.oe_req      = r_oe_req;

endmodule
`default_nettype wire

// File: tb/tb_spi_host_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_host_bridge
// Brief    : Scoreboard bench for spi_host_bridge with a simple chip-side model.
// Revision : 1.0
// ============================================================================
module tb_spi_host_bridge;
    localparam int           W         = 32;
    localparam int           SCK_DIV   = 2;
    localparam int           TURN      = 2;
    localparam logic [W-1:0] CHIP_WORD = 32'hCAFE_F00D;
    localparam logic [2*W+5:0] RST_VEC = {2'b00, {(2*W){1'b0}}, 4'b1101};

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    spi_host_bridge_if #(.SPI_WIDTH(W)) bus ();

    spi_host_bridge #(
        .SPI_WIDTH   (W),
        .SCK_DIV     (SCK_DIV),
        .TURN_CYCLES (TURN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Chip model: drives its config word only while requesting and the host has let go.
    logic chip_drv;
    assign chip_drv       = bus.config_req && !bus.oe_req;
    assign bus.spi_data_i = chip_drv ? CHIP_WORD : '0;

    logic [2*W+5:0] out_vec;
    assign out_vec = {bus.tx_ready, bus.cfg_valid, bus.cfg_data, bus.spi_data_o,
                      bus.spi_data_oe, bus.oe_req, bus.spi_sck, bus.spi_cs_n};

    logic [W-1:0] stim_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_q[$];
    logic [W-1:0] cfg_exp_q[$];
    logic [W-1:0] cfg_obs_q[$];
    int           rise_cyc_q[$];
    int           ready_cnt    = 0;
    int           cfg_rise_cnt = 0;
    int           overlap_cnt  = 0;
    int           first_ready  = -1;
    logic         prev_sck     = 1'b0;

    always @(negedge clk) begin
        if (bus.spi_sck && !prev_sck) begin
            if (bus.spi_data_oe && !bus.spi_cs_n) begin
                obs_q.push_back(bus.spi_data_o);
                rise_cyc_q.push_back(cyc);
            end else if (!bus.spi_data_oe) begin
                cfg_rise_cnt <= cfg_rise_cnt + 1;
            end
        end
        prev_sck <= bus.spi_sck;
        if (bus.tx_ready)               ready_cnt   <= ready_cnt + 1;
        if (bus.cfg_valid)              cfg_obs_q.push_back(bus.cfg_data);
        if (bus.spi_data_oe && chip_drv) overlap_cnt <= overlap_cnt + 1;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic feed_words();
        while (stim_q.size() > 0) begin
            logic [W-1:0] w;
            int           n;
            w = stim_q.pop_front();
            bus.tx_data  = w;
            bus.tx_valid = 1'b1;
            exp_q.push_back(w);
            n = 0;
            do begin
                tick();
                n++;
            end while (!bus.tx_ready && n < 200);
            vectors++;
            if (bus.tx_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL accept_timeout: tx_ready=%b for word %h after %0d cycles, required 1", bus.tx_ready, w, n);
            end else if (first_ready < 0) begin
                first_ready = cyc;
            end
        end
        bus.tx_valid = 1'b0;
    endtask

    task automatic drain_scoreboard(input string tag);
        logic [W-1:0] got;
        logic [W-1:0] want;
        while (obs_q.size() > 0) begin
            got = obs_q.pop_front();
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL %s_extra_word: chip saw %h, required no word", tag, got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    miscompares++;
                    $display("FAIL %s_word: chip saw %h, required %h", tag, got, want);
                end
            end
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_missing_words: %0d words never reached chip, required 0", tag, exp_q.size());
            exp_q.delete();
        end
        while (cfg_obs_q.size() > 0) begin
            got = cfg_obs_q.pop_front();
            vectors++;
            if (cfg_exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL %s_extra_cfg: cfg_valid with %h, required none", tag, got);
            end else begin
                want = cfg_exp_q.pop_front();
                if (got !== want) begin
                    miscompares++;
                    $display("FAIL %s_cfg_data: got %h, required %h", tag, got, want);
                end
            end
        end
        vectors++;
        if (cfg_exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_missing_cfg: %0d config words not captured, required 0", tag, cfg_exp_q.size());
            cfg_exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        bus.tx_valid    = 1'b0;
        bus.tx_data     = '0;
        bus.config_req  = 1'b0;
        bus.near_full   = 1'b0;
        repeat (3) tick();
        vectors++;
        if (out_vec !== RST_VEC) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h, required %h", out_vec, RST_VEC);
        end
        rst_n = 1'b1;
        repeat (3) tick();
        vectors++;
        if (out_vec !== RST_VEC) begin
            miscompares++;
            $display("FAIL idle_outputs: got %h, required %h", out_vec, RST_VEC);
        end
    endtask

    task automatic test_stream();
        int r0;
        int cs_high;
        r0          = ready_cnt;
        cs_high     = 0;
        first_ready = -1;
        rise_cyc_q.delete();
        stim_q = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        fork
            feed_words();
            begin
                int n;
                n = 0;
                while (first_ready < 0 && n < 100) begin tick(); n++; end
                while (rise_cyc_q.size() < 4 && n < 200) begin
                    if (bus.spi_cs_n) cs_high++;
                    tick();
                    n++;
                end
            end
        join
        repeat (4) tick();
        vectors++;
        if (ready_cnt - r0 != 4) begin
            miscompares++;
            $display("FAIL stream_ready_pulses: got %0d, required 4", ready_cnt - r0);
        end
        vectors++;
        if (rise_cyc_q.size() == 0 || rise_cyc_q[0] - first_ready != SCK_DIV) begin
            miscompares++;
            $display("FAIL stream_first_sck: rise-accept gap %0d, required %0d",
                     (rise_cyc_q.size() > 0) ? rise_cyc_q[0] - first_ready : -1, SCK_DIV);
        end
        for (int i = 1; i < rise_cyc_q.size(); i++) begin
            vectors++;
            if (rise_cyc_q[i] - rise_cyc_q[i-1] != 2*SCK_DIV+1) begin
                miscompares++;
                $display("FAIL stream_period: edge %0d spacing %0d, required %0d", i, rise_cyc_q[i] - rise_cyc_q[i-1], 2*SCK_DIV+1);
            end
        end
        vectors++;
        if (cs_high != 0) begin
            miscompares++;
            $display("FAIL stream_cs_n: high for %0d cycles in burst, required 0", cs_high);
        end
        vectors++;
        if (bus.spi_cs_n !== 1'b1) begin
            miscompares++;
            $display("FAIL stream_cs_idle: cs_n=%b after burst, required 1", bus.spi_cs_n);
        end
        drain_scoreboard("stream");
    endtask

    task automatic test_near_full();
        int r0;
        r0 = ready_cnt;
        stim_q = {32'h5555_0001, 32'h5555_0002, 32'h5555_0003, 32'h5555_0004, 32'h5555_0005, 32'h5555_0006};
        fork
            feed_words();
            begin
                int n;
                int at_nf;
                int base;
                n = 0;
                while (ready_cnt - r0 < 2 && n < 100) begin tick(); n++; end
                bus.near_full = 1'b1;
                repeat (30) tick();
                at_nf = ready_cnt - r0;
                vectors++;
                if (at_nf < 2 || at_nf > 3) begin
                    miscompares++;
                    $display("FAIL nf_stop: %0d words accepted, required 2..3", at_nf);
                end
                repeat (20) tick();
                vectors++;
                if (ready_cnt - r0 != at_nf) begin
                    miscompares++;
                    $display("FAIL nf_hold: %0d words accepted, required %0d", ready_cnt - r0, at_nf);
                end
                bus.near_full = 1'b0;
                base = ready_cnt;
                n = 0;
                while (ready_cnt == base && n < 20) begin tick(); n++; end
                vectors++;
                if (ready_cnt == base || n > 3) begin
                    miscompares++;
                    $display("FAIL nf_resume: took %0d cycles, required <= 3", n);
                end
            end
        join
        repeat (8) tick();
        drain_scoreboard("near_full");
    endtask

    task automatic test_config();
        int n;
        int c0;
        int t_oe0;
        int t_req0;
        int t_req1;
        int t_oe1;
        c0 = cfg_rise_cnt;
        t_oe0 = -1; t_req0 = -1; t_req1 = -1; t_oe1 = -1;
        bus.config_req = 1'b1;
        cfg_exp_q.push_back(CHIP_WORD);
        n = 0;
        while (t_oe1 < 0 && n < 60) begin
            tick();
            n++;
            if (t_oe0 < 0 && !bus.spi_data_oe)                 t_oe0  = cyc;
            if (t_req0 < 0 && !bus.oe_req)                     t_req0 = cyc;
            if (t_req0 >= 0 && t_req1 < 0 && bus.oe_req)       t_req1 = cyc;
            if (t_oe0 >= 0 && t_oe1 < 0 && bus.spi_data_oe)    t_oe1  = cyc;
            if (bus.cfg_valid)                                 bus.config_req = 1'b0;
        end
        vectors++;
        if (t_oe0 < 0 || t_req0 - t_oe0 != TURN) begin
            miscompares++;
            $display("FAIL cfg_release_gap: oe_req fell %0d cycles after oe, required %0d", t_req0 - t_oe0, TURN);
        end
        vectors++;
        if (t_req1 < 0 || t_oe1 - t_req1 != TURN) begin
            miscompares++;
            $display("FAIL cfg_reclaim_gap: oe rose %0d cycles after oe_req, required %0d", t_oe1 - t_req1, TURN);
        end
        vectors++;
        if (t_oe1 < 0 || t_oe1 - t_oe0 != 3*TURN + 2*SCK_DIV) begin
            miscompares++;
            $display("FAIL cfg_round_trip: oe low for %0d cycles, required %0d", t_oe1 - t_oe0, 3*TURN + 2*SCK_DIV);
        end
        vectors++;
        if (cfg_rise_cnt - c0 != 1) begin
            miscompares++;
            $display("FAIL cfg_sck_pulses: got %0d, required 1", cfg_rise_cnt - c0);
        end
        repeat (10) tick();
        vectors++;
        if ({bus.spi_data_oe, bus.oe_req, bus.cfg_data} !== {2'b11, CHIP_WORD}) begin
            miscompares++;
            $display("FAIL cfg_after: oe=%b oe_req=%b cfg_data=%h, required 1 1 %h", bus.spi_data_oe, bus.oe_req, bus.cfg_data, CHIP_WORD);
        end
        drain_scoreboard("config");
    endtask

    task automatic test_cfg_priority();
        int t_cfg;
        int t_rdy;
        t_cfg = -1;
        t_rdy = -1;
        bus.config_req = 1'b1;
        cfg_exp_q.push_back(CHIP_WORD);
        tick();
        tick();
        stim_q = {32'hA5A5_5A5A};
        fork
            feed_words();
            begin
                int n;
                n = 0;
                while ((t_cfg < 0 || t_rdy < 0) && n < 80) begin
                    tick();
                    n++;
                    if (bus.cfg_valid) begin
                        t_cfg = cyc;
                        bus.config_req = 1'b0;
                    end
                    if (bus.tx_ready && t_rdy < 0) t_rdy = cyc;
                end
            end
        join
        vectors++;
        if (t_cfg < 0 || t_rdy <= t_cfg) begin
            miscompares++;
            $display("FAIL cfg_priority: cfg_valid at %0d, tx_ready at %0d, required config first", t_cfg, t_rdy);
        end
        repeat (8) tick();
        drain_scoreboard("priority");
    endtask

    task automatic test_cfg_midword();
        int r0;
        int t_oe0;
        r0          = ready_cnt;
        t_oe0       = -1;
        first_ready = -1;
        stim_q = {32'h0BAD_CAFE};
        fork
            feed_words();
            begin
                int n;
                n = 0;
                while (ready_cnt == r0 && n < 50) begin tick(); n++; end
                bus.config_req = 1'b1;
                cfg_exp_q.push_back(CHIP_WORD);
                while (n < 100) begin
                    tick();
                    n++;
                    if (t_oe0 < 0 && !bus.spi_data_oe) t_oe0 = cyc;
                    if (bus.cfg_valid) begin
                        bus.config_req = 1'b0;
                        n = 100;
                    end
                end
            end
        join
        vectors++;
        if (t_oe0 < 0 || first_ready < 0 || t_oe0 - first_ready != 2*SCK_DIV+1) begin
            miscompares++;
            $display("FAIL midword_release: bus released %0d cycles after accept, required %0d", t_oe0 - first_ready, 2*SCK_DIV+1);
        end
        repeat (8) tick();
        drain_scoreboard("midword");
    endtask

    task automatic test_reset_mid_cfg();
        int n;
        bus.config_req = 1'b1;
        n = 0;
        while (!(bus.spi_sck && !bus.spi_data_oe) && n < 40) begin tick(); n++; end
        vectors++;
        if (!(bus.spi_sck === 1'b1 && bus.spi_data_oe === 1'b0)) begin
            miscompares++;
            $display("FAIL rst_reach_cfg_hi: sck=%b oe=%b, required 1 0", bus.spi_sck, bus.spi_data_oe);
        end
        rst_n          = 1'b0;
        bus.config_req = 1'b0;
        #1;
        vectors++;
        if (out_vec !== RST_VEC) begin
            miscompares++;
            $display("FAIL rst_async_outputs: got %h, required %h", out_vec, RST_VEC);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (12) tick();
        vectors++;
        if (cfg_obs_q.size() != 0) begin
            miscompares++;
            $display("FAIL rst_no_cfg_valid: %0d captures, required 0", cfg_obs_q.size());
            cfg_obs_q.delete();
        end
        stim_q = {32'h7777_0001, 32'h7777_0002};
        feed_words();
        repeat (8) tick();
        drain_scoreboard("post_reset");
    endtask

    initial begin
        test_reset();
        test_stream();
        test_near_full();
        test_config();
        test_cfg_priority();
        test_cfg_midword();
        test_reset_mid_cfg();
        vectors++;
        if (overlap_cnt != 0) begin
            miscompares++;
            $display("FAIL bus_overlap: %0d cycles with both drivers, required 0", overlap_cnt);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
